// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller:
// R-type funct codes, MEM bundle bit positions and hazard FSM states.
package pipe_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int unsigned MEM_READ_BIT  = 1;
  localparam int unsigned MEM_WRITE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } hz_state_e;

  function automatic logic is_div(input logic rtype, input logic [5:0] funct);
    return rtype && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));
  endfunction

  function automatic logic is_mult(input logic rtype, input logic [5:0] funct);
    return rtype && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
  endfunction

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Combinational load-use comparator: flags when the load in ID/EX writes a
// register (other than $zero) that the instruction in ID reads.
module hazard_loaduse_cmp (
  input  logic       mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  output logic       hazard
);

  // Destination match against either source operand
  always_comb begin
    hazard = mem_read && (id_ex_rt != 5'd0) &&
             ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS pipeline.
// Inserts a 1-cycle bubble on load-use and freezes the front of the pipe
// for multi-cycle DIV/DIVU. Optional macro MULT_STALL_EN also freezes for
// MULT/MULTU (MUL_CYCLES cycles); without it MUL_CYCLES is unused.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic [1:0]       id_ex_mem,
  input  logic [4:0]       id_ex_rt,
  input  logic [5:0]       id_ex_funct,
  input  logic             id_ex_rtype,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             id_bubble,
  output logic             ex_bubble,
  output logic             muldiv_start,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  hz_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             div_hit;
  logic             mul_hit;
  logic             lu_hit;
  logic             unused_mem_write;

  assign unused_mem_write = id_ex_mem[MEM_WRITE_BIT];
  assign div_hit          = is_div(id_ex_rtype, id_ex_funct);

`ifdef MULT_STALL_EN
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  assign mul_hit = is_mult(id_ex_rtype, id_ex_funct);
`else
  localparam int unsigned unused_mul_cycles = MUL_CYCLES;
  assign mul_hit = 1'b0;
`endif

  hazard_loaduse_cmp u_loaduse (
    .mem_read (id_ex_mem[MEM_READ_BIT]),
    .id_ex_rt (id_ex_rt),
    .if_id_rs (if_id_rs),
    .if_id_rt (if_id_rt),
    .hazard   (lu_hit)
  );

  // Busy FSM and remaining-cycle counter; counter never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_hit) begin
            cnt   <= DIV_LOAD;
            state <= MD_BUSY;
          end
`ifdef MULT_STALL_EN
          else if (mul_hit) begin
            cnt   <= MUL_LOAD;
            state <= MD_BUSY;
          end
`endif
        end
        MD_BUSY: begin
          if (cnt == '0) state <= MD_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        MD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Enables and bubble selects; rst forces the free-running defaults even
  // while the state register still holds MD_BUSY
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    id_bubble    = 1'b0;
    ex_bubble    = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = 1'b0;
    stall_cnt    = rst ? '0 : cnt;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (div_hit || mul_hit) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_bubble    = 1'b1;
            muldiv_start = 1'b1;
            muldiv_busy  = 1'b1;
          end else if (lu_hit) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          ex_bubble   = 1'b1;
          muldiv_busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (DIV_CYCLES 32 and 4)
// share the same stimulus; a freeze-countdown reference model predicts each
// cycle's outputs and a negedge monitor compares them.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MUL_N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic [1:0] id_ex_mem;
  logic [5:0] id_ex_funct;
  logic       id_ex_rtype;

  logic       pc_en_a, if_id_en_a, id_ex_en_a, id_bubble_a, ex_bubble_a, start_a, busy_a;
  logic       pc_en_b, if_id_en_b, id_ex_en_b, id_bubble_b, ex_bubble_b, start_b, busy_b;
  logic [5:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(32), .MUL_CYCLES(MUL_N), .CNT_W(6)) u_dut_a (
    .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_mem(id_ex_mem), .id_ex_rt(id_ex_rt), .id_ex_funct(id_ex_funct),
    .id_ex_rtype(id_ex_rtype), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
    .id_ex_en(id_ex_en_a), .id_bubble(id_bubble_a), .ex_bubble(ex_bubble_a),
    .muldiv_start(start_a), .muldiv_busy(busy_a), .stall_cnt(cnt_a));

  pipe_hazard_ctrl #(.DIV_CYCLES(4), .MUL_CYCLES(MUL_N), .CNT_W(6)) u_dut_b (
    .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_mem(id_ex_mem), .id_ex_rt(id_ex_rt), .id_ex_funct(id_ex_funct),
    .id_ex_rtype(id_ex_rtype), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .id_ex_en(id_ex_en_b), .id_bubble(id_bubble_b), .ex_bubble(ex_bubble_b),
    .muldiv_start(start_b), .muldiv_busy(busy_b), .stall_cnt(cnt_b));

  // {pc_en, if_id_en, id_ex_en, id_bubble, ex_bubble, start, busy, cnt[5:0]}
  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model: busy cycles still to come (after the detect cycle) and a flag for
  // the single result cycle that follows the freeze
  int   busy_left [2] = '{0, 0};
  bit   done_cyc  [2] = '{0, 0};
  int   div_n     [2] = '{32, 4};

  localparam logic [12:0] RUN_FREE = {3'b111, 4'b0000, 6'd0};
  localparam logic [12:0] LOADUSE  = {3'b001, 4'b1000, 6'd0};
  localparam logic [12:0] START    = {3'b000, 4'b0111, 6'd0};

  function automatic logic [12:0] frozen(input int remaining);
    logic [5:0] c;
    c = 6'(remaining - 1);
    return {3'b000, 4'b0101, c};
  endfunction

  task automatic predict(input int k, output logic [12:0] e);
    bit is_d, is_m, lu;
    is_d = id_ex_rtype && (id_ex_funct == 6'h1A || id_ex_funct == 6'h1B);
`ifdef MULT_STALL_EN
    is_m = id_ex_rtype && (id_ex_funct == 6'h18 || id_ex_funct == 6'h19);
`else
    is_m = 1'b0;
`endif
    lu = id_ex_mem[1] && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    if (rst) begin
      e = RUN_FREE; busy_left[k] = 0; done_cyc[k] = 0;
    end else if (busy_left[k] > 0) begin
      e = frozen(busy_left[k]);
      busy_left[k]--;
      if (busy_left[k] == 0) done_cyc[k] = 1;
    end else if (done_cyc[k]) begin
      e = RUN_FREE; done_cyc[k] = 0;
    end else if (is_d) begin
      e = START; busy_left[k] = div_n[k] - 1;
    end else if (is_m) begin
      e = START; busy_left[k] = MUL_N - 1;
    end else if (lu) begin
      e = LOADUSE;
    end else begin
      e = RUN_FREE;
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] mem, input logic [4:0] xrt,
                       input logic [5:0] fn, input logic rty);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; if_id_rs = rs; if_id_rt = rt; id_ex_mem = mem;
    id_ex_rt = xrt; id_ex_funct = fn; id_ex_rtype = rty;
    cycle++;
    predict(0, x.a);
    predict(1, x.b);
    x.cyc = cycle;
    sb.push_back(x);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd1, 5'd2, 2'b00, 5'd3, 6'h20, 1'b1);
  endtask

  task automatic hold_funct(input int n, input logic [5:0] fn);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd8, 5'd9, 2'b00, 5'd0, fn, 1'b1);
  endtask

  // Monitor: compare whatever the DUTs present against the queued prediction
  always @(negedge clk) begin
    logic [12:0] got_a, got_b;
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      got_a = {pc_en_a, if_id_en_a, id_ex_en_a, id_bubble_a, ex_bubble_a, start_a, busy_a, cnt_a};
      got_b = {pc_en_b, if_id_en_b, id_ex_en_b, id_bubble_b, ex_bubble_b, start_b, busy_b, cnt_b};
      checks++;
      if (got_a !== x.a) begin
        errors++;
        $display("FAIL outs_div32 cycle %0d: got %b expected %b", x.cyc, got_a, x.a);
      end
      checks++;
      if (got_b !== x.b) begin
        errors++;
        $display("FAIL outs_div4 cycle %0d: got %b expected %b", x.cyc, got_b, x.b);
      end
    end
  end

  initial begin
    int drain;
    logic [5:0] fn_tbl [5];
    fn_tbl[0] = 6'h1A; fn_tbl[1] = 6'h1B; fn_tbl[2] = 6'h18;
    fn_tbl[3] = 6'h19; fn_tbl[4] = 6'h20;
    rst = 1'b1; if_id_rs = '0; if_id_rt = '0; id_ex_mem = '0;
    id_ex_rt = '0; id_ex_funct = '0; id_ex_rtype = 1'b0;

    // Reset then run-free
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 6'h00, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 6'h00, 1'b0);
    idle_cycles(3);

    // Load-use match on rs, on rt, then rt = $zero (no stall)
    drive(1'b0, 5'd8, 5'd3, 2'b10, 5'd8, 6'h20, 1'b0);
    idle_cycles(1);
    drive(1'b0, 5'd4, 5'd8, 2'b10, 5'd8, 6'h20, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 2'b10, 5'd0, 6'h20, 1'b0);
    drive(1'b0, 5'd8, 5'd8, 2'b01, 5'd8, 6'h20, 1'b0);
    idle_cycles(2);

    // DIVU held in ID/EX through the whole freeze
    hold_funct(34, 6'h1B);
    idle_cycles(2);

    // DIV with a simultaneous load-use condition
    for (int i = 0; i < 34; i++) drive(1'b0, 5'd8, 5'd9, 2'b10, 5'd8, 6'h1A, 1'b1);
    idle_cycles(2);

    // Back-to-back DIVs
    hold_funct(70, 6'h1A);
    idle_cycles(2);

    // Reset in the middle of a DIVU freeze
    hold_funct(10, 6'h1B);
    drive(1'b1, 5'd8, 5'd9, 2'b00, 5'd0, 6'h1B, 1'b1);
    drive(1'b1, 5'd8, 5'd9, 2'b00, 5'd0, 6'h1B, 1'b1);
    idle_cycles(3);

    // MULTU: freezes only when the feature is built in
    hold_funct(6, 6'h19);
    idle_cycles(2);

    // Randomised traffic with a small register space to provoke matches
    for (int i = 0; i < 900; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      drive(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? fn_tbl[$urandom_range(0, 3)] : fn_tbl[4],
            1'($urandom));
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
